param_arf: RTL and testbench
============================

PARAM_ARF -- requirements
Module: param_arf

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register, I, OutA and OutB.
REQ-002 Parameter NUM_REGS, default 4, number of registers (legal range 2..16).
REQ-003 Parameter STEP, default 1, increment/decrement amount (must satisfy 1 <= STEP < 2^WIDTH).
REQ-004 Derived SEL_W = max(1, clog2(NUM_REGS)), width of the read-select ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 I  input  WIDTH  load data.
REQ-008 FunSel  input  2  operation: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-009 RSel  input  NUM_REGS  per-register write enable; bit k enables register k.
REQ-010 OutASel  input  SEL_W  read select, port A.
REQ-011 OutBSel  input  SEL_W  read select, port B.
REQ-012 OutA  output  WIDTH  contents of register OutASel.
REQ-013 OutB  output  WIDTH  contents of register OutBSel.
REQ-014 WrapFlag  output  NUM_REGS  sticky per-register wrap/saturation flag.

Function
REQ-015 Each register k with RSel[k]=1 SHALL update at the rising clk edge per FunSel; registers with RSel[k]=0 SHALL hold.
REQ-016 Load SHALL write I; clear SHALL write 0 and clear WrapFlag[k].
REQ-017 Increment SHALL compute R+STEP and decrement R-STEP, modulo 2^WIDTH (default build).
REQ-018 WrapFlag[k] SHALL set on the edge where an increment carries out of WIDTH bits or a decrement borrows, and SHALL stay set until clear or reset; load SHALL NOT change it.
REQ-019 Multiple RSel bits set SHALL apply the same operation to all selected registers in the same cycle; RSel=0 SHALL be a no-op.
REQ-020 OutA/OutB SHALL be combinational from register state (zero-latency read); a write becomes visible one cycle after the edge.
REQ-021 A select value >= NUM_REGS SHALL drive the corresponding output to 0.
REQ-022 OutASel=OutBSel SHALL drive identical values on both ports.
REQ-023 Any bits of RSel or FunSel that are X/undriven are illegal; no behaviour is defined for them.

Reset
REQ-024 rst=1 at a rising edge SHALL set every register to 0 and WrapFlag to 0, overriding any FunSel/RSel in that cycle.
REQ-025 After reset, OutA=OutB=0 for all selects until the first write.
REQ-026 Reset asserted between operations SHALL discard no pending state beyond the registers themselves (block has no multi-cycle operations).

Configuration
REQ-027 Macro PARAM_ARF_SAT_EN: when defined, increment SHALL saturate at 2^WIDTH-1 and decrement at 0, setting WrapFlag[k] whenever saturation limits the result.
REQ-028 Without PARAM_ARF_SAT_EN, arithmetic SHALL wrap per REQ-017 and WrapFlag SHALL mark wrap events per REQ-018.

Verification
REQ-029 Defaults; rst=1 one cycle, then all OutASel values -> OutA=0, WrapFlag=0000.
REQ-030 I=0x08, FunSel=10, RSel=1111; next cycle OutASel=2, OutBSel=3 -> OutA=OutB=0x08.
REQ-031 From all 0x08: FunSel=01, RSel=1001 for 3 cycles -> R0=R3=0x0B, R1=R2=0x08.
REQ-032 Load R1=0xFF, FunSel=01, RSel=0010 one cycle -> R1=0x00, WrapFlag[1]=1 (SAT_EN: R1=0xFF, WrapFlag[1]=1); then FunSel=10 I=0x10 -> R1=0x10, WrapFlag[1] still 1; then FunSel=11 -> R1=0, WrapFlag[1]=0.
REQ-033 R2=0x00, FunSel=00, RSel=0100 -> R2=0xFF, WrapFlag[2]=1 (SAT_EN: R2=0x00, WrapFlag[2]=1); same cycle rst=1 variant -> R2=0, WrapFlag=0.
REQ-034 WIDTH=12, NUM_REGS=6, STEP=4: load R5=0x004, decrement twice -> 0x000 then 0xFFC with WrapFlag[5]=1; OutASel=6 or 7 -> OutA=0.

Source files
------------

// File: rtl/param_arf_if.sv
// Bus bundle for the parameterised register file: write controls, dual read selects,
// read data and the sticky wrap flags.
interface param_arf_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int SEL_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  logic [WIDTH-1:0]    I;
  logic [1:0]          FunSel;
  logic [NUM_REGS-1:0] RSel;
  logic [SEL_W-1:0]    OutASel;
  logic [SEL_W-1:0]    OutBSel;
  logic [WIDTH-1:0]    OutA;
  logic [WIDTH-1:0]    OutB;
  logic [NUM_REGS-1:0] WrapFlag;

  modport master (
    output I, FunSel, RSel, OutASel, OutBSel,
    input  OutA, OutB, WrapFlag
  );

  modport slave (
    input  I, FunSel, RSel, OutASel, OutBSel,
    output OutA, OutB, WrapFlag
  );
endinterface

// File: rtl/param_arf.sv
// Parameterised register file with per-register inc/dec/load/clear, two combinational
// read ports and sticky wrap flags. Define PARAM_ARF_SAT_EN for saturating arithmetic.
module param_arf #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int STEP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  param_arf_if.slave  bus
);
  localparam int SEL_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  typedef enum logic [1:0] {
    OP_DEC  = 2'b00,
    OP_INC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0]    reg_q [NUM_REGS];
  logic [WIDTH-1:0]    reg_d [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_q;
  logic [NUM_REGS-1:0] wrap_d;
  op_e                 op;

  // Result packs {limit_hit, value}; limit_hit is the carry/borrow out of WIDTH bits.
  function automatic logic [WIDTH:0] inc_op(input logic [WIDTH-1:0] r);
    logic [WIDTH:0] sum;
    sum = {1'b0, r} + STEP_X;
`ifdef PARAM_ARF_SAT_EN
    return sum[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : sum;
`else
    return sum;
`endif
  endfunction

  function automatic logic [WIDTH:0] dec_op(input logic [WIDTH-1:0] r);
    logic [WIDTH:0] diff;
    diff = {1'b0, r} - STEP_X;
`ifdef PARAM_ARF_SAT_EN
    return diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
`else
    return diff;
`endif
  endfunction

  assign op = op_e'(bus.FunSel);

  always_comb begin
    logic [WIDTH:0] res;
    wrap_d = wrap_q;
    res    = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k] = reg_q[k];
      if (bus.RSel[k]) begin
        unique case (op)
          OP_DEC: begin
            res       = dec_op(reg_q[k]);
            reg_d[k]  = res[WIDTH-1:0];
            wrap_d[k] = wrap_q[k] | res[WIDTH];
          end
          OP_INC: begin
            res       = inc_op(reg_q[k]);
            reg_d[k]  = res[WIDTH-1:0];
            wrap_d[k] = wrap_q[k] | res[WIDTH];
          end
          OP_LOAD: reg_d[k] = bus.I;
          OP_CLR: begin
            reg_d[k]  = '0;
            wrap_d[k] = 1'b0;
          end
          default: reg_d[k] = reg_q[k];
        endcase
      end
    end
  end

  // State update: reset overrides any write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= '0;
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= reg_d[k];
      wrap_q <= wrap_d;
    end
  end

  // Read ports: selects with no matching register fall through to zero.
  always_comb begin
    bus.OutA = '0;
    bus.OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.OutASel == SEL_W'(k)) bus.OutA = reg_q[k];
      if (bus.OutBSel == SEL_W'(k)) bus.OutB = reg_q[k];
    end
  end

  assign bus.WrapFlag = wrap_q;
endmodule

// File: tb/tb_param_arf.sv
// Scoreboard bench: a default-parameter instance and a WIDTH=12/NUM_REGS=6/STEP=4 instance.
module tb_param_arf;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  param_arf_if #(.WIDTH(8),  .NUM_REGS(4)) b0 ();
  param_arf_if #(.WIDTH(12), .NUM_REGS(6)) b1 ();

  param_arf #(.WIDTH(8), .NUM_REGS(4), .STEP(1)) dut0 (
    .clk(clk), .rst(rst0), .bus(b0.slave));
  param_arf #(.WIDTH(12), .NUM_REGS(6), .STEP(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave));

  typedef struct {
    int          dut;
    string       name;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ew;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: read ports settle combinationally, so sample on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] aa, ab, aw;
      e = sb.pop_front();
      if (e.dut == 0) begin
        aa = 16'(b0.OutA); ab = 16'(b0.OutB); aw = 16'(b0.WrapFlag);
      end else begin
        aa = 16'(b1.OutA); ab = 16'(b1.OutB); aw = 16'(b1.WrapFlag);
      end
      vectors++;
      if (aa !== e.ea || ab !== e.eb || aw !== e.ew) begin
        miscompares++;
        $display("FAIL %s: got A=%h B=%h W=%h, expected A=%h B=%h W=%h",
                 e.name, aa, ab, aw, e.ea, e.eb, e.ew);
      end
    end
  end

  task automatic op0(input logic [1:0] f, input logic [3:0] rs, input logic [7:0] d);
    b0.FunSel = f; b0.RSel = rs; b0.I = d;
    @(posedge clk); #1;
    b0.RSel = '0;
  endtask

  task automatic op1(input logic [1:0] f, input logic [5:0] rs, input logic [11:0] d);
    b1.FunSel = f; b1.RSel = rs; b1.I = d;
    @(posedge clk); #1;
    b1.RSel = '0;
  endtask

  task automatic chk(input int dut, input string n, input logic [3:0] a, input logic [3:0] b,
                     input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ew);
    exp_t e;
    if (dut == 0) begin
      b0.RSel = '0; b0.OutASel = a[1:0]; b0.OutBSel = b[1:0];
    end else begin
      b1.RSel = '0; b1.OutASel = a[2:0]; b1.OutBSel = b[2:0];
    end
    e.dut = dut; e.name = n; e.ea = ea; e.eb = eb; e.ew = ew;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

`ifdef PARAM_ARF_SAT_EN
  localparam logic [15:0] INC_FF   = 16'h00FF;
  localparam logic [15:0] DEC_00   = 16'h0000;
  localparam logic [15:0] DEC_W12  = 16'h0000;
`else
  localparam logic [15:0] INC_FF   = 16'h0000;
  localparam logic [15:0] DEC_00   = 16'h00FF;
  localparam logic [15:0] DEC_W12  = 16'h0FFC;
`endif

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.I = '0; b0.FunSel = 2'b10; b0.RSel = '0; b0.OutASel = '0; b0.OutBSel = '0;
    b1.I = '0; b1.FunSel = 2'b10; b1.RSel = '0; b1.OutASel = '0; b1.OutBSel = '0;
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < 4; i++)
      chk(0, $sformatf("reset_sel%0d", i), 4'(i), 4'(3 - i), 16'h0, 16'h0, 16'h0);

    op0(2'b10, 4'b1111, 8'h08);
    chk(0, "load_all_23", 4'd2, 4'd3, 16'h08, 16'h08, 16'h0);
    chk(0, "load_all_01", 4'd0, 4'd1, 16'h08, 16'h08, 16'h0);

    for (int i = 0; i < 3; i++) op0(2'b01, 4'b1001, 8'h00);
    chk(0, "inc3_01", 4'd0, 4'd1, 16'h0B, 16'h08, 16'h0);
    chk(0, "inc3_32", 4'd3, 4'd2, 16'h0B, 16'h08, 16'h0);

    op0(2'b10, 4'b0010, 8'hFF);
    op0(2'b01, 4'b0010, 8'h00);
    chk(0, "inc_wrap_r1", 4'd1, 4'd1, INC_FF, INC_FF, 16'h2);
    op0(2'b10, 4'b0010, 8'h10);
    chk(0, "load_keeps_flag", 4'd1, 4'd0, 16'h10, 16'h0B, 16'h2);
    op0(2'b11, 4'b0010, 8'h00);
    chk(0, "clear_r1", 4'd1, 4'd0, 16'h00, 16'h0B, 16'h0);

    op0(2'b11, 4'b0100, 8'h00);
    op0(2'b00, 4'b0100, 8'h00);
    chk(0, "dec_borrow_r2", 4'd2, 4'd3, DEC_00, 16'h0B, 16'h4);

    op0(2'b11, 4'b0100, 8'h00);
    b0.FunSel = 2'b00; b0.RSel = 4'b0100; rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; b0.RSel = '0;
    chk(0, "rst_over_dec_22", 4'd2, 4'd2, 16'h0, 16'h0, 16'h0);
    chk(0, "rst_over_dec_03", 4'd0, 4'd3, 16'h0, 16'h0, 16'h0);

    op1(2'b10, 6'b100000, 12'h004);
    chk(1, "w12_load_r5", 4'd5, 4'd0, 16'h004, 16'h000, 16'h0);
    op1(2'b00, 6'b100000, 12'h000);
    chk(1, "w12_dec_to_0", 4'd5, 4'd5, 16'h000, 16'h000, 16'h0);
    op1(2'b00, 6'b100000, 12'h000);
    chk(1, "w12_dec_wrap_sel6", 4'd6, 4'd5, 16'h000, DEC_W12, 16'h20);
    chk(1, "w12_dec_wrap_sel7", 4'd7, 4'd5, 16'h000, DEC_W12, 16'h20);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
